// File: rtl/cloud_bg_writer.sv
// ---------------------------------------------------------------------------
// cloud_bg_writer
//
// Rectangle blitter for the 256x256 background framebuffer. It takes a
// valid/ready stream of RGB pixels and writes them in raster order into a
// programmable rectangle. Each write address is {y, x}. Pixels equal to the
// transparent key colour are consumed without being written.
//
// Parameters:
//   COLOR_W    pixel width (4:4:4 RGB by default)
//   ADDR_W     framebuffer address width, {y[7:0], x[7:0]}
//   KEY_EN     enables transparent-key skipping
//   KEY_COLOR  transparent key value
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   start      command pulse, sampled only while idle
//   x0, y0     rectangle origin (column, row), latched on start
//   w_m1, h_m1 rectangle width/height minus one, latched on start
//   pix_valid  source has a pixel
//   pix_data   pixel value
//   pix_ready  block accepts a pixel this cycle
//   wr_en      framebuffer write strobe (one cycle after accept)
//   wr_addr    framebuffer write address
//   wr_data    framebuffer write data
//   busy       command in progress
//   done       one-cycle pulse alongside the final pixel's write slot
// ---------------------------------------------------------------------------
module cloud_bg_writer #(
  parameter int                 COLOR_W   = 12,
  parameter int                 ADDR_W    = 16,
  parameter bit                 KEY_EN    = 1'b1,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         x0,
  input  logic [7:0]         y0,
  input  logic [7:0]         w_m1,
  input  logic [7:0]         h_m1,
  input  logic               pix_valid,
  input  logic [COLOR_W-1:0] pix_data,
  output logic               pix_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0] x0_q;
  logic [7:0] y0_q;
  logic [7:0] w_m1_q;
  logic [7:0] h_m1_q;
  logic [7:0] col;
  logic [7:0] row;

  logic       accept;
  logic       last_pix;
  logic       is_key;
  logic [7:0] addr_x;
  logic [7:0] addr_y;

  assign accept   = (state == RUN) && pix_valid;
  assign last_pix = (col == w_m1_q) && (row == h_m1_q);
  assign is_key   = KEY_EN && (pix_data == KEY_COLOR);

  // 8-bit sums wrap naturally, so rectangles crossing the right or bottom
  // edge continue at column 0 / row 0.
  assign addr_x = x0_q + col;
  assign addr_y = y0_q + row;

  // pix_ready and busy come straight from the state flop, so both are
  // registered and change the cycle after start / the last accept.
  assign pix_ready = (state == RUN);
  assign busy      = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (accept && last_pix) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, raster counters and the one-stage write pipeline.
  // wr_en and done default low each cycle so they are single-cycle pulses;
  // address/data hold their last value between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_m1_q  <= '0;
      h_m1_q  <= '0;
      col     <= '0;
      row     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;

      if ((state == IDLE) && start) begin
        x0_q   <= x0;
        y0_q   <= y0;
        w_m1_q <= w_m1;
        h_m1_q <= h_m1;
        col    <= '0;
        row    <= '0;
      end

      if (accept) begin
        wr_en   <= !is_key;
        wr_addr <= ADDR_W'({addr_y, addr_x});
        wr_data <= pix_data;
        done    <= last_pix;
        if (col == w_m1_q) begin
          col <= '0;
          row <= row + 8'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cloud_bg_writer.sv
// ---------------------------------------------------------------------------
// tb_cloud_bg_writer
//
// Self-checking bench for cloud_bg_writer. A behavioural model follows the
// command/raster rules. For every accepted pixel it pushes the expected
// write slot (enable, address, data, done) into a scoreboard queue. The slot
// is popped and compared one clock later, when the DUT presents it.
// ---------------------------------------------------------------------------
module tb_cloud_bg_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  x0;
  logic [7:0]  y0;
  logic [7:0]  w_m1;
  logic [7:0]  h_m1;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        pix_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;

  cloud_bg_writer #(
    .COLOR_W  (12),
    .ADDR_W   (16),
    .KEY_EN   (1'b1),
    .KEY_COLOR(12'hF0F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w_m1     (w_m1),
    .h_m1     (h_m1),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_ready(pix_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr_en;
    logic [15:0] addr;
    logic [11:0] data;
    logic        done;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Model state.
  logic       m_run = 1'b0;
  logic [7:0] m_x0 = '0;
  logic [7:0] m_y0 = '0;
  logic [7:0] m_w = '0;
  logic [7:0] m_h = '0;
  logic [7:0] m_col = '0;
  logic [7:0] m_row = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  task automatic setRect(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] wm1, input logic [7:0] hm1);
    x0 = x;
    y0 = y;
    w_m1 = wm1;
    h_m1 = hm1;
  endtask

  // Drives one cycle of stimulus, advances the model, then checks the
  // cycle the DUT presents after the clock edge.
  task automatic applyStimulus(input logic s, input logic v, input logic [11:0] d);
    exp_t e;
    logic nxt_run;
    logic last;
    logic [7:0] ax;
    logic [7:0] ay;
    start = s;
    pix_valid = v;
    pix_data = d;
    nxt_run = m_run;
    if (!m_run) begin
      if (s) begin
        m_x0 = x0;
        m_y0 = y0;
        m_w = w_m1;
        m_h = h_m1;
        m_col = '0;
        m_row = '0;
        nxt_run = 1'b1;
      end
    end else if (v) begin
      last = (m_col == m_w) && (m_row == m_h);
      ax = m_x0 + m_col;
      ay = m_y0 + m_row;
      e.wr_en = (d != 12'hF0F);
      e.addr = {ay, ax};
      e.data = d;
      e.done = last;
      if (e.wr_en || e.done) sb.push_back(e);
      if (m_col == m_w) begin
        m_col = '0;
        m_row = m_row + 8'd1;
      end else begin
        m_col = m_col + 8'd1;
      end
      if (last) nxt_run = 1'b0;
    end
    @(posedge clk);
    #1;
    m_run = nxt_run;
    checkOutput("busy", {31'd0, busy}, {31'd0, m_run});
    checkOutput("pix_ready", {31'd0, pix_ready}, {31'd0, m_run});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("wr_en", {31'd0, wr_en}, {31'd0, e.wr_en});
      checkOutput("done", {31'd0, done}, {31'd0, e.done});
      if (e.wr_en) begin
        checkOutput("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
        checkOutput("wr_data", {20'd0, wr_data}, {20'd0, e.data});
      end
    end else begin
      checkOutput("wr_en_quiet", {31'd0, wr_en}, 32'd0);
      checkOutput("done_quiet", {31'd0, done}, 32'd0);
    end
  endtask

  // One reset cycle; everything must be at reset values afterwards.
  task automatic doReset(input logic v);
    rst = 1'b1;
    start = 1'b0;
    pix_valid = v;
    pix_data = 12'h0AA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    m_run = 1'b0;
    m_col = '0;
    m_row = '0;
    sb.delete();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    checkOutput("rst_wr_data", {20'd0, wr_data}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    setRect(8'd0, 8'd0, 8'd0, 8'd0);
    @(posedge clk);
    #1;
    doReset(1'b0);

    $display("[TB] 4x2 rectangle at (10,20)");
    setRect(8'd10, 8'd20, 8'd3, 8'd1);
    applyStimulus(1'b1, 1'b0, 12'h000);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 12'(i));
    applyStimulus(1'b0, 1'b0, 12'h000);

    $display("[TB] wrap at bottom-right corner");
    setRect(8'd254, 8'd255, 8'd2, 8'd1);
    applyStimulus(1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 12'(12'h100 + i));
    applyStimulus(1'b0, 1'b0, 12'h000);

    $display("[TB] stall pattern");
    setRect(8'd7, 8'd3, 8'd2, 8'd0);
    applyStimulus(1'b1, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 12'h201);
    applyStimulus(1'b0, 1'b0, 12'h2FF);
    applyStimulus(1'b0, 1'b0, 12'h2FE);
    applyStimulus(1'b0, 1'b1, 12'h202);
    applyStimulus(1'b0, 1'b1, 12'h203);
    applyStimulus(1'b0, 1'b0, 12'h000);

    $display("[TB] transparency");
    setRect(8'd30, 8'd40, 8'd0, 8'd2);
    applyStimulus(1'b1, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 12'h123);
    applyStimulus(1'b0, 1'b1, 12'hF0F);
    applyStimulus(1'b0, 1'b1, 12'h456);
    applyStimulus(1'b0, 1'b0, 12'h000);
    setRect(8'd60, 8'd61, 8'd1, 8'd0);
    applyStimulus(1'b1, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 12'h111);
    applyStimulus(1'b0, 1'b1, 12'hF0F);
    applyStimulus(1'b0, 1'b0, 12'h000);

    $display("[TB] start while busy, then back-to-back start");
    setRect(8'd5, 8'd5, 8'd1, 8'd1);
    applyStimulus(1'b1, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 12'h301);
    setRect(8'd100, 8'd100, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 12'h302);
    applyStimulus(1'b0, 1'b1, 12'h303);
    applyStimulus(1'b0, 1'b1, 12'h304);
    applyStimulus(1'b1, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 12'h3AA);
    applyStimulus(1'b0, 1'b0, 12'h000);

    $display("[TB] reset mid-run");
    setRect(8'd50, 8'd60, 8'd2, 8'd1);
    applyStimulus(1'b1, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 12'h401);
    applyStimulus(1'b0, 1'b1, 12'h402);
    doReset(1'b1);
    applyStimulus(1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 12'(12'h500 + i));
    applyStimulus(1'b0, 1'b0, 12'h000);

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
